tag_tx_ctrl: RTL and testbench
==============================

# tag_tx_ctrl

Slot-based backscatter frame transmitter, directly downstream of the random-access MAC. At every slot boundary it samples the MAC's one-bit transmit grant. On grant it sends one Manchester-coded frame on the modulation switch: preamble, tag ID, and optional CRC-8. Otherwise it stays silent for that slot.

## Interface
Parameters:
- SLOT_CYCLES, 512: clk cycles per slot; must be ≥ FRAME_BITS·BIT_CYCLES + 1.
- BIT_CYCLES, 8: clk cycles per frame bit; even, ≥ 2.
- PREAMBLE, 8'hA5: preamble bits, sent MSB first.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: run control; low = idle and counters cleared.
- mac_out, in, 1: MAC transmit grant, sampled only on slot_start cycles.
- tag_id, in, 16: tag identifier; latched at frame start.
- mod_out, out, 1: modulation switch drive (registered).
- busy, out, 1: high while a frame is being sent.
- slot_start, out, 1: one-cycle pulse on the first cycle of each slot.
- frame_done, out, 1: one-cycle pulse after the last chip of a completed frame.

## Operation
- Frame format: PREAMBLE[7:0], then tag_id[15:0], then (with CRC option) crc[7:0]. All fields MSB first. FRAME_BITS = 24, or 32 with CRC.
- Manchester coding: each bit lasts BIT_CYCLES cycles.
  - First BIT_CYCLES/2 cycles: mod_out = bit.
  - Second half: mod_out = ~bit.
- slot_cnt counts 0..SLOT_CYCLES-1 and wraps to 0. It runs freely while enable=1, in every state.
- slot_start = enable & (slot_cnt == 0).
- States:
  - IDLE: entered when enable=0. slot_cnt=0, mod_out=0. Goes to LISTEN on the first cycle with enable=1; that same cycle is a slot_start.
  - LISTEN: on a slot_start with mac_out=1, latch tag_id, reset bit/chip counters, go to TX. With mac_out=0, stay in LISTEN; the slot is skipped.
  - TX: shift out FRAME_BITS bits. After the last chip, pulse frame_done, set mod_out=0 and go to LISTEN. The rest of the slot stays silent.
- A slot_start inside TX cannot occur; the parameter constraint guarantees it. No frame ever spans two slots.
- enable falling in any state: next edge goes to IDLE, mod_out=0, busy=0. An aborted frame gives no frame_done.
- rst has priority over enable. Reset values: mod_out=0, busy=0, slot_start=0, frame_done=0, state IDLE, slot_cnt=0, latched ID=0, CRC register=0.
- Changes on tag_id during TX are ignored.

## Timing
- Cycle S = slot_start with mac_out=1.
  - Cycle S+1: busy=1 and mod_out carries the first half-chip of PREAMBLE[7].
  - Bit k covers cycles S+1+k·BIT_CYCLES through S+(k+1)·BIT_CYCLES.
- frame_done is high in cycle S+1+FRAME_BITS·BIT_CYCLES. busy and mod_out are 0 in that same cycle.
- Grant-to-air latency is 1 cycle. mac_out must be valid in the slot_start cycle; other cycles are don't-care.
- Back-to-back grants in consecutive slots give consecutive frames, separated by SLOT_CYCLES − FRAME_BITS·BIT_CYCLES idle cycles.

## Configuration
- TAG_TX_CRC8_EN defined:
  - Appends a CRC-8 over the 16 tag_id bits only, computed MSB first.
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - FRAME_BITS = 32.
- Not defined: no CRC logic, FRAME_BITS = 24, and frame_done is 8·BIT_CYCLES earlier.

## Structure
- Package tag_tx_pkg holds:
  - the state type (IDLE, LISTEN, TX);
  - the CRC8_POLY constant;
  - the field widths PRE_BITS=8, ID_BITS=16, CRC_BITS=8;
  - the FRAME_BITS derivation.
- Sub-module crc8_serial (clk, rst, clear, shift, din, crc[7:0]):
  - clear is asserted at frame start.
  - shift is asserted once per ID bit, at that bit's first cycle.
  - The CRC is complete before the first CRC bit is sent.
- The top module holds the slot counter, the FSM, the chip/bit counters and the frame shift register.

## Test plan
- Reset mid-frame: assert rst at bit 10 of a frame → next edge mod_out=0, busy=0, no frame_done; next slot_start appears on the cycle enable is seen after rst falls.
- Grant denied: mac_out=0 at every slot_start for 4 slots → mod_out stays 0, busy stays 0, slot_start pulses every 512 cycles.
- Basic frame (no CRC): BIT_CYCLES=8, tag_id=16'h1234, grant at cycle S → mod_out =1 in S+1..S+4, =0 in S+5..S+8 (preamble bit 1); full 24-bit Manchester pattern matches A5_1234; frame_done at S+193.
- CRC frame (TAG_TX_CRC8_EN): tag_id=16'h1234 → trailing byte 8'hF1; frame_done at S+257.
- Enable drop: deassert enable at cycle S+50 → mod_out=0 at S+51, no frame_done; re-enable → slot_start on the first enabled cycle.
- Latching: change tag_id from 16'h1234 to 16'hFFFF at cycle S+100 → transmitted ID is still 16'h1234; the next granted slot sends 16'hFFFF.

Source files
------------

// File: rtl/tag_tx_pkg.sv
// Shared types and constants for the slot-based backscatter frame transmitter.
// Define TAG_TX_CRC8_EN to append a CRC-8 over the tag ID to every frame.
package tag_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LISTEN = 2'd1,
    TX     = 2'd2
  } tx_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int PRE_BITS = 8;
  localparam int ID_BITS  = 16;
  localparam int CRC_BITS = 8;
  localparam int HDR_BITS = PRE_BITS + ID_BITS;

`ifdef TAG_TX_CRC8_EN
  localparam int FRAME_BITS = HDR_BITS + CRC_BITS;
`else
  localparam int FRAME_BITS = HDR_BITS;
`endif

endpackage

// File: rtl/tag_tx_ctrl_crc8.sv
// Bit-serial CRC-8 (poly 0x07, init 0, MSB first, no reflection, no final XOR).
// Only instantiated when TAG_TX_CRC8_EN is defined.
module crc8_serial
  import tag_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift,
  input  logic       din,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[7] ^ din;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= 8'h00;
    end else if (shift) begin
      crc <= {crc[6:0], 1'b0} ^ ({8{fb}} & CRC8_POLY);
    end
  end

endmodule

// File: rtl/tag_tx_ctrl.sv
// Slot-timed Manchester frame transmitter: preamble, tag ID and, with
// TAG_TX_CRC8_EN defined, a trailing CRC-8 over the tag ID.
module tag_tx_ctrl
  import tag_tx_pkg::*;
#(
  parameter int         SLOT_CYCLES = 512,
  parameter int         BIT_CYCLES  = 8,
  parameter logic [7:0] PREAMBLE    = 8'hA5
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  logic      mac_out,
  input  logic [15:0] tag_id,
  output logic      mod_out,
  output logic      busy,
  output logic      slot_start,
  output logic      frame_done,
  output tx_state_e state_dbg
);

  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int CW = $clog2(BIT_CYCLES);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CHIP_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CHIP_HALF = CW'(BIT_CYCLES / 2);
  localparam logic [5:0]    BIT_LAST  = 6'(FRAME_BITS - 1);

  tx_state_e state_q, state_d;

  logic [SW-1:0]       slot_cnt_q;
  logic [CW-1:0]       chip_q, chip_d, chip_nx;
  logic [5:0]          bit_q, bit_d, bit_nx;
  logic [HDR_BITS-1:0] sr_q, sr_d;
  logic                mod_q, mod_d;
  logic                done_q, done_d;
  logic                grant, last_chip, last_bit;
  logic                cur_bit, nxt_bit;

  // slot_start is suppressed while rst is held so reset outputs read 0.
  assign slot_start = enable & ~rst & (slot_cnt_q == '0);
  assign grant      = slot_start & mac_out & (state_q == LISTEN);
  assign last_chip  = (chip_q == CHIP_LAST);
  assign last_bit   = (bit_q == BIT_LAST);
  assign chip_nx    = chip_q + CW'(1);
  assign bit_nx     = bit_q + 6'd1;

`ifdef TAG_TX_CRC8_EN
  localparam logic [5:0] ID_FIRST = 6'(PRE_BITS);
  localparam logic [5:0] ID_END   = 6'(HDR_BITS);

  logic [7:0] crc;
  logic       crc_clear, crc_shift;

  // One CRC step per ID bit, on that bit's first chip; the last step lands
  // one cycle into bit 23, well before the first CRC bit is needed.
  assign crc_clear = grant;
  assign crc_shift = (state_q == TX) && (chip_q == '0) &&
                     (bit_q >= ID_FIRST) && (bit_q < ID_END);

  crc8_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear),
    .shift (crc_shift),
    .din   (sr_q[HDR_BITS-1]),
    .crc   (crc)
  );

  // CRC bits start at index 24, a multiple of 8, so ~idx[2:0] picks MSB first.
  assign cur_bit = (bit_q  >= ID_END) ? crc[~bit_q[2:0]]  : sr_q[HDR_BITS-1];
  assign nxt_bit = (bit_nx >= ID_END) ? crc[~bit_nx[2:0]] : sr_q[HDR_BITS-2];
`else
  assign cur_bit = sr_q[HDR_BITS-1];
  assign nxt_bit = sr_q[HDR_BITS-2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = LISTEN;
        LISTEN:  if (grant) state_d = TX;
        TX:      if (last_chip && last_bit) state_d = LISTEN;
        default: state_d = IDLE;
      endcase
    end
  end

  // mod_out is registered, so this computes the chip for the next cycle.
  always_comb begin
    mod_d  = 1'b0;
    done_d = 1'b0;
    chip_d = chip_q;
    bit_d  = bit_q;
    sr_d   = sr_q;
    if (enable) begin
      if (grant) begin
        sr_d   = {PREAMBLE, tag_id};
        chip_d = '0;
        bit_d  = '0;
        mod_d  = PREAMBLE[7];
      end else if (state_q == TX) begin
        if (!last_chip) begin
          chip_d = chip_nx;
          mod_d  = (chip_nx < CHIP_HALF) ? cur_bit : ~cur_bit;
        end else if (!last_bit) begin
          chip_d = '0;
          bit_d  = bit_nx;
          sr_d   = {sr_q[HDR_BITS-2:0], 1'b0};
          mod_d  = nxt_bit;
        end else begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      chip_q     <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      mod_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (!enable || slot_cnt_q == SLOT_LAST) begin
        slot_cnt_q <= '0;
      end else begin
        slot_cnt_q <= slot_cnt_q + SW'(1);
      end
      chip_q <= chip_d;
      bit_q  <= bit_d;
      sr_q   <= sr_d;
      mod_q  <= mod_d;
      done_q <= done_d;
    end
  end

  assign mod_out    = mod_q;
  assign frame_done = done_q;
  assign busy       = (state_q == TX);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_tag_tx_ctrl.sv
// Directed bench for tag_tx_ctrl; expectations follow TAG_TX_CRC8_EN if defined.
module tb_tag_tx_ctrl;
  import tag_tx_pkg::*;

  localparam int SLOT = 512;
  localparam int BC   = 8;
`ifdef TAG_TX_CRC8_EN
  localparam int EXP_DONE = 257;
  localparam int EXP_GAP  = 256;
`else
  localparam int EXP_DONE = 193;
  localparam int EXP_GAP  = 320;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mac_out;
  logic [15:0] tag_id;
  logic        mod_out, busy, slot_start, frame_done;
  tx_state_e   state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic cap [0:300];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tag_tx_ctrl #(.SLOT_CYCLES(SLOT), .BIT_CYCLES(BC), .PREAMBLE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mac_out    (mac_out),
    .tag_id     (tag_id),
    .mod_out    (mod_out),
    .busy       (busy),
    .slot_start (slot_start),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef TAG_TX_CRC8_EN
  function automatic logic [7:0] ref_crc(input logic [15:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  function automatic logic [31:0] exp_frame(input logic [15:0] id);
`ifdef TAG_TX_CRC8_EN
    return {8'hA5, id, (id == 16'h1234) ? 8'hF1 : ref_crc(id)};
`else
    return {8'hA5, id, 8'h00};
`endif
  endfunction

  function automatic logic [15:0] cap_id();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[15-i] = cap[1 + (8 + i) * BC];
    return v;
  endfunction

  // Steps at least once, then up to one slot for the next slot_start.
  task automatic wait_slot(output int s);
    int n;
    step();
    n = 1;
    while (slot_start !== 1'b1 && n < SLOT + 2) begin
      step();
      n++;
    end
    checks++;
    if (slot_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_slot_start: slot_start=%b after %0d cycles, required 1", slot_start, n);
    end
    s = cyc;
  endtask

  // Called in a slot_start cycle; grants it and checks every chip of the frame.
  task automatic run_frame(input logic [15:0] id, input int chg_at, input logic [15:0] new_id,
                           output int s, output int done_at);
    logic [31:0] f;
    logic        exp_b;
    int          bad, first_bad, k, ph, nchip;
    nchip     = FRAME_BITS * BC;
    bad       = 0;
    first_bad = -1;
    done_at   = -1;
    tag_id    = id;
    mac_out   = 1'b1;
    s         = cyc;
    f         = exp_frame(id);
    for (int c = 1; c <= nchip; c++) begin
      step();
      if (c == 1) mac_out = 1'b0;
      cap[c] = mod_out;
      k      = (c - 1) / BC;
      ph     = (c - 1) % BC;
      exp_b  = (ph < BC / 2) ? f[31-k] : ~f[31-k];
      if (mod_out !== exp_b || busy !== 1'b1 || frame_done !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (c == chg_at) tag_id = new_id;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_pattern id=%h: %0d bad cycles (first at S+%0d), required 0", id, bad, first_bad);
    end
    step();
    if (frame_done === 1'b1) done_at = cyc - s;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || mod_out !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: done=%b busy=%b mod=%b, required 1 0 0", frame_done, busy, mod_out);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse: frame_done=%b one cycle later, required 0", frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; mac_out = 1'b0; tag_id = 16'h0000;
    step();
    step();
    checks++;
    if (mod_out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || slot_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: mod=%b busy=%b done=%b start=%b, required 0 0 0 0",
               mod_out, busy, frame_done, slot_start);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required %0d", state_dbg, IDLE);
    end
    enable = 1'b0;
    rst    = 1'b0;
    step();
  endtask

  task automatic test_grant_denied();
    int last, pulses, bad_int, act;
    enable = 1'b1;
    mac_out = 1'b0;
    #1;
    checks++;
    if (slot_start !== 1'b1) begin
      errors++;
      $display("FAIL first_enabled_slot_start: slot_start=%b, required 1", slot_start);
    end
    last = cyc; pulses = 0; bad_int = 0; act = 0;
    for (int n = 1; n <= 4 * SLOT; n++) begin
      step();
      if (busy !== 1'b0 || mod_out !== 1'b0 || frame_done !== 1'b0) act++;
      if (slot_start === 1'b1) begin
        pulses++;
        if (cyc - last != SLOT) bad_int++;
        last = cyc;
      end
    end
    checks++;
    if (pulses != 4 || bad_int != 0) begin
      errors++;
      $display("FAIL denied_slot_pulses: %0d pulses, %0d bad intervals, required 4 and 0", pulses, bad_int);
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL denied_silent: %0d active cycles, required 0", act);
    end
  endtask

  task automatic test_basic_frame();
    int s, d, ones, zeros;
    wait_slot(s);
    run_frame(16'h1234, -1, 16'h0000, s, d);
    ones = 0; zeros = 0;
    for (int c = 1; c <= 4; c++) if (cap[c] === 1'b1) ones++;
    for (int c = 5; c <= 8; c++) if (cap[c] === 1'b0) zeros++;
    checks++;
    if (ones != 4 || zeros != 4) begin
      errors++;
      $display("FAIL preamble_bit7: %0d ones in S+1..4, %0d zeros in S+5..8, required 4 and 4", ones, zeros);
    end
    checks++;
    if (d != EXP_DONE) begin
      errors++;
      $display("FAIL frame_done_time: S+%0d, required S+%0d", d, EXP_DONE);
    end
    checks++;
    if (cap_id() !== 16'h1234) begin
      errors++;
      $display("FAIL sent_id: %h, required 1234", cap_id());
    end
`ifdef TAG_TX_CRC8_EN
    begin
      logic [7:0] cb;
      for (int i = 0; i < 8; i++) cb[7-i] = cap[1 + (24 + i) * BC];
      checks++;
      if (cb !== 8'hF1) begin
        errors++;
        $display("FAIL crc_byte: %h, required f1", cb);
      end
    end
`endif
  endtask

  task automatic test_back_to_back();
    int s1, s2, d, gap;
    wait_slot(s1);
    run_frame(16'hBEEF, -1, 16'h0000, s1, d);
    wait_slot(s2);
    checks++;
    if (s2 - s1 != SLOT) begin
      errors++;
      $display("FAIL b2b_slot_period: %0d cycles, required %0d", s2 - s1, SLOT);
    end
    gap = s2 - (s1 + d) + 1;
    checks++;
    if (gap != EXP_GAP) begin
      errors++;
      $display("FAIL b2b_idle_gap: %0d idle cycles, required %0d", gap, EXP_GAP);
    end
    run_frame(16'h0F0F, -1, 16'h0000, s2, d);
  endtask

  task automatic test_latching();
    int s, d;
    wait_slot(s);
    run_frame(16'h1234, 100, 16'hFFFF, s, d);
    checks++;
    if (cap_id() !== 16'h1234) begin
      errors++;
      $display("FAIL latched_id: %h, required 1234", cap_id());
    end
    wait_slot(s);
    run_frame(16'hFFFF, -1, 16'h0000, s, d);
    checks++;
    if (cap_id() !== 16'hFFFF) begin
      errors++;
      $display("FAIL next_slot_id: %h, required ffff", cap_id());
    end
  endtask

  task automatic test_enable_drop();
    int s, stray;
    wait_slot(s);
    tag_id  = 16'h1234;
    mac_out = 1'b1;
    step();
    mac_out = 1'b0;
    for (int n = 2; n <= 50; n++) step();
    enable = 1'b0;
    step();
    checks++;
    if (mod_out !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL enable_drop: mod=%b busy=%b state=%0d, required 0 0 %0d", mod_out, busy, state_dbg, IDLE);
    end
    stray = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (frame_done !== 1'b0 || slot_start !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL enable_drop_quiet: %0d cycles with done/start, required 0", stray);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (slot_start !== 1'b1) begin
      errors++;
      $display("FAIL reenable_slot_start: slot_start=%b, required 1", slot_start);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s, r, n2, stray;
    wait_slot(s);
    tag_id  = 16'hFFFF;
    mac_out = 1'b1;
    step();
    mac_out = 1'b0;
    for (int n = 2; n <= 81; n++) step();
    rst = 1'b1;
    step();
    checks++;
    if (mod_out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: mod=%b busy=%b done=%b, required 0 0 0", mod_out, busy, frame_done);
    end
    step();
    checks++;
    if (slot_start !== 1'b0) begin
      errors++;
      $display("FAIL slot_start_in_reset: slot_start=%b, required 0", slot_start);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (slot_start !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_slot_start: slot_start=%b, required 1", slot_start);
    end
    r = cyc;
    stray = 0;
    for (int n = 0; n < 300; n++) begin
      step();
      if (frame_done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: %0d active cycles, required 0", stray);
    end
    wait_slot(n2);
    checks++;
    if (n2 - r != SLOT) begin
      errors++;
      $display("FAIL post_reset_period: %0d cycles, required %0d", n2 - r, SLOT);
    end
  endtask

  initial begin
    test_reset();
    test_grant_denied();
    test_basic_frame();
    test_back_to_back();
    test_latching();
    test_enable_drop();
    step();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
